i2c_cmd_queue: RTL and testbench
================================

I2C_CMD_QUEUE -- requirements
Module: i2c_cmd_queue

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO entries (power of two, 2..16).
REQ-002 Parameter TIMEOUT_CYCLES, default 4096, done watchdog limit in clk cycles (used only with I2C_CMDQ_TIMEOUT_EN).
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cmd_valid  input  1  host offers command.
REQ-006 cmd_ready  output  1  queue accepts command (FIFO not full).
REQ-007 cmd_op  input  1  0 = write, 1 = read.
REQ-008 cmd_addr  input  7  target slave address.
REQ-009 cmd_data  input  8  write data (ignored for reads).
REQ-010 newd  output  1  start strobe to I2C master.
REQ-011 op  output  1  operation to I2C master.
REQ-012 addr  output  7  address to I2C master.
REQ-013 din  output  8  write data to I2C master.
REQ-014 busy  input  1  I2C master busy.
REQ-015 done  input  1  I2C master transaction complete.
REQ-016 ack_err  input  1  I2C master NACK flag, valid with done.
REQ-017 dout  input  8  I2C master read data, valid with done.
REQ-018 rsp_valid  output  1  response available.
REQ-019 rsp_ready  input  1  host consumes response.
REQ-020 rsp_op  output  1  op of completed command.
REQ-021 rsp_data  output  8  read data; 0x00 for writes.
REQ-022 rsp_err  output  1  ack_err captured, or timeout.
REQ-023 rsp_timeout  output  1  completion forced by watchdog.
REQ-024 cmd_count  output  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-025 Push when cmd_valid && cmd_ready; cmd_ready = (cmd_count < DEPTH); push on full never occurs, entry never overwritten.
REQ-026 FIFO pointers wrap modulo DEPTH; push and pop in same cycle leave cmd_count unchanged.
REQ-027 FSM states IDLE, ISSUE, WAIT, RESP.
REQ-028 IDLE -> ISSUE when cmd_count != 0 and busy == 0; otherwise remain.
REQ-029 ISSUE: newd = 1 for exactly one cycle, op/addr/din driven from FIFO head, head popped same cycle, -> WAIT.
REQ-030 op/addr/din hold the issued values, unchanged, from ISSUE until next ISSUE.
REQ-031 WAIT: on done rising edge (done=1, previous-cycle done=0) capture rsp_op, rsp_data = op ? dout : 0x00, rsp_err = ack_err, rsp_timeout = 0, -> RESP.
REQ-032 done already high on entry to WAIT is not a completion; a new rising edge is required.
REQ-033 RESP: rsp_valid = 1, rsp fields stable until rsp_valid && rsp_ready; then -> IDLE; at most one command outstanding.
REQ-034 Minimum latency push-to-newd: 2 cycles (push cycle, IDLE cycle, newd in ISSUE) when idle and busy = 0.
REQ-035 FIFO accepts pushes in every state, including RESP and WAIT.

Reset
REQ-036 rst asserted at any time, including mid-WAIT: FSM -> IDLE, FIFO emptied, cmd_count = 0, cmd_ready = 1 after release, newd = 0, op = 0, addr = 0, din = 0, rsp_valid = 0, rsp_op = 0, rsp_data = 0, rsp_err = 0, rsp_timeout = 0, watchdog = 0.
REQ-037 An in-flight I2C transaction interrupted by rst produces no response.

Configuration
REQ-038 Macro I2C_CMDQ_TIMEOUT_EN defined: WAIT counter, cleared on ISSUE; reaching TIMEOUT_CYCLES without done rising edge -> RESP with rsp_data = 0x00, rsp_err = 1, rsp_timeout = 1.
REQ-039 Macro undefined: no counter; WAIT exits only on done rising edge; rsp_timeout tied 0.

Verification
REQ-040 Reset, push write (0x5A, 0x3C), master model pulses done after 20 cycles, ack_err = 0 -> one newd pulse with addr 0x5A, din 0x3C, op 0; rsp_valid, rsp_data 0x00, rsp_err 0.
REQ-041 Push read 0x5A, model returns dout 0x3C with done -> rsp_op 1, rsp_data 0x3C, rsp_err 0.
REQ-042 Push 5 commands with DEPTH = 4, master stalled (busy = 1) -> cmd_ready = 0 after 4th, cmd_count = 4, 5th held until first pop; commands issued in push order.
REQ-043 Write completes with ack_err = 1 -> rsp_err 1; rsp_ready held 0 for 10 cycles -> no new newd until consumed.
REQ-044 Assert rst during WAIT with 2 queued -> all outputs at reset values, cmd_count 0, no rsp_valid.
REQ-045 With I2C_CMDQ_TIMEOUT_EN, TIMEOUT_CYCLES = 50, no done -> rsp_valid 50 cycles after ISSUE, rsp_err 1, rsp_timeout 1; without macro, rsp_valid stays 0.

Source files
------------

// File: rtl/i2c_cmd_queue.sv
// I2C command queue: host commands are buffered in a FIFO and issued one at a time to an I2C master.
// Each command yields one response. Defining I2C_CMDQ_TIMEOUT_EN adds a done watchdog.
//
// state   | meaning
// S_IDLE  | no command outstanding, waiting for a queued entry and master not busy
// S_ISSUE | newd strobe, FIFO head driven on op/addr/din and popped
// S_WAIT  | waiting for a fresh done rising edge (or watchdog expiry)
// S_RESP  | response held on rsp_* until the host takes it
module i2c_cmd_queue #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_op,
  input  logic [6:0]               cmd_addr,
  input  logic [7:0]               cmd_data,
  output logic                     newd,
  output logic                     op,
  output logic [6:0]               addr,
  output logic [7:0]               din,
  input  logic                     busy,
  input  logic                     done,
  input  logic                     ack_err,
  input  logic [7:0]               dout,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_op,
  output logic [7:0]               rsp_data,
  output logic                     rsp_err,
  output logic                     rsp_timeout,
  output logic [$clog2(DEPTH):0]   cmd_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [15:0]   w_head;
  logic          w_push;
  logic          w_pop;
  logic          w_load;
  logic          w_capture;

  logic          r_done_q;
  logic          w_done_rise;
  logic          w_wd_expire;

  logic          r_op;
  logic [6:0]    r_addr;
  logic [7:0]    r_din;
  logic          r_rsp_op;
  logic [7:0]    r_rsp_data;
  logic          r_rsp_err;

  if ((DEPTH < 2) || (DEPTH > 16) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("i2c_cmd_queue: DEPTH must be a power of two in 2..16");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("i2c_cmd_queue: TIMEOUT_CYCLES must be at least 2");
  end

  assign cmd_ready = (r_count < CW'(DEPTH));
  assign cmd_count = r_count;
  assign w_push    = cmd_valid & cmd_ready;
  assign w_pop     = (r_state == S_ISSUE);
  assign w_head    = r_mem[r_rd_ptr];

  // Storage needs no reset: occupancy and pointers alone define valid entries.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {cmd_op, cmd_addr, cmd_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done_q <= 1'b0;
    end else begin
      r_done_q <= done;
    end
  end

  assign w_done_rise = done & ~r_done_q;

`ifdef I2C_CMDQ_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WW-1:0] r_wd;
  logic          r_rsp_timeout;

  // Loaded in ISSUE so that expiry lands RESP exactly TIMEOUT_CYCLES after the strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wd <= '0;
    end else if (r_state == S_ISSUE) begin
      r_wd <= WW'(TIMEOUT_CYCLES - 2);
    end else if ((r_state == S_WAIT) && (r_wd != '0)) begin
      r_wd <= r_wd - WW'(1);
    end
  end

  assign w_wd_expire = (r_state == S_WAIT) && (r_wd == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_timeout <= 1'b0;
    end else if (w_capture) begin
      r_rsp_timeout <= ~w_done_rise;
    end
  end

  assign rsp_timeout = r_rsp_timeout;
`else
  assign w_wd_expire = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    newd        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((r_count != '0) && !busy) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        newd        = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (w_done_rise || w_wd_expire) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_load    = (r_state == S_IDLE) && (w_state_nxt == S_ISSUE);
  assign w_capture = (r_state == S_WAIT) && (w_state_nxt == S_RESP);

  // Head is latched one cycle early so op/addr/din are already valid during the newd strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op   <= 1'b0;
      r_addr <= '0;
      r_din  <= '0;
    end else if (w_load) begin
      {r_op, r_addr, r_din} <= w_head;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_op   <= 1'b0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else if (w_capture) begin
      r_rsp_op <= r_op;
      if (w_done_rise) begin
        r_rsp_data <= r_op ? dout : 8'h00;
        r_rsp_err  <= ack_err;
      end else begin
        r_rsp_data <= 8'h00;
        r_rsp_err  <= 1'b1;
      end
    end
  end

  assign op        = r_op;
  assign addr      = r_addr;
  assign din       = r_din;
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_op    = r_rsp_op;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_i2c_cmd_queue.sv
// Bench for i2c_cmd_queue: transaction-level model checked every cycle plus directed literal checks.
module tb_i2c_cmd_queue;
  localparam int DEPTH = 4;
  localparam int TO    = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_op = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_data = '0;
  logic       newd;
  logic       op;
  logic [6:0] addr;
  logic [7:0] din;
  logic       busy = 1'b0;
  logic       done = 1'b0;
  logic       ack_err = 1'b0;
  logic [7:0] dout = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic       rsp_op;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       rsp_timeout;
  logic [2:0] cmd_count;

  i2c_cmd_queue #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .newd(newd), .op(op), .addr(addr), .din(din),
    .busy(busy), .done(done), .ack_err(ack_err), .dout(dout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .cmd_count(cmd_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic [15:0] m_q[$];
  logic [15:0] m_hold = '0;
  logic [15:0] iss_log[$];
  bit          m_out = 0;
  bit          m_waiting = 0;
  bit          m_avail = 0;
  int          m_wait_k = 0;
  logic        m_done_prev = 1'b0;
  logic        m_exp_op, m_exp_err, m_exp_to;
  logic [7:0]  m_exp_data;
  int          n_newd = 0;
  int          newd_cyc = 0;

  always @(negedge clk) begin
    if (rst) begin
      m_q.delete();
      m_hold      = '0;
      m_out       = 0;
      m_waiting   = 0;
      m_avail     = 0;
      m_wait_k    = 0;
      m_done_prev = 1'b0;
    end else begin
      chk("cmd_count", int'(cmd_count), m_q.size());
      chk("cmd_ready", int'(cmd_ready), int'(m_q.size() < DEPTH));
      chk("rsp_valid", int'(rsp_valid), int'(m_avail));
      if (m_avail) begin
        chk("rsp_op", int'(rsp_op), int'(m_exp_op));
        chk("rsp_data", int'(rsp_data), int'(m_exp_data));
        chk("rsp_err", int'(rsp_err), int'(m_exp_err));
        chk("rsp_timeout", int'(rsp_timeout), int'(m_exp_to));
      end
      if (newd) begin
        chk("newd_allowed", int'(!m_out && (m_q.size() > 0)), 1);
        if (m_q.size() > 0) chk("issue_word", int'({op, addr, din}), int'(m_q[0]));
      end else begin
        chk("issue_hold", int'({op, addr, din}), int'(m_hold));
      end

      // advance the model to what the next clock edge must produce
      if (m_avail && rsp_ready) begin
        m_avail = 0;
        m_out   = 0;
      end
      if (m_waiting) begin
        m_wait_k++;
        if (done && !m_done_prev) begin
          m_waiting  = 0;
          m_avail    = 1;
          m_exp_op   = m_hold[15];
          m_exp_data = m_hold[15] ? dout : 8'h00;
          m_exp_err  = ack_err;
          m_exp_to   = 1'b0;
        end
`ifdef I2C_CMDQ_TIMEOUT_EN
        else if (m_wait_k == TO - 1) begin
          m_waiting  = 0;
          m_avail    = 1;
          m_exp_op   = m_hold[15];
          m_exp_data = 8'h00;
          m_exp_err  = 1'b1;
          m_exp_to   = 1'b1;
        end
`endif
      end
      if (newd && (m_q.size() > 0)) begin
        m_hold    = m_q.pop_front();
        m_out     = 1;
        m_waiting = 1;
        m_wait_k  = 0;
        n_newd++;
        newd_cyc  = cyc;
        iss_log.push_back({op, addr, din});
      end
      if (cmd_valid && cmd_ready) m_q.push_back({cmd_op, cmd_addr, cmd_data});
      m_done_prev = done;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic o, input logic [6:0] a, input logic [7:0] d, output int acc);
    bit got = 0;
    acc = -1;
    cmd_valid = 1'b1; cmd_op = o; cmd_addr = a; cmd_data = d;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        got = 1;
        acc = cyc;
      end
      tick();
    end
    cmd_valid = 1'b0;
    if (!got) chk("push_accepted", 0, 1);
  endtask

  task automatic wait_issue(input int target);
    bit got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      #1;
      if (n_newd >= target) got = 1;
    end
    if (!got) chk("issue_seen", 0, 1);
    tick();
  endtask

  task automatic pulse_done(input logic [7:0] d, input logic e);
    done = 1'b1; dout = d; ack_err = e;
    tick();
    done = 1'b0; ack_err = 1'b0;
  endtask

  task automatic wait_rsp(input int bound, output bit got, output int at,
                          output logic ro, output logic [7:0] rd, output logic re, output logic rt);
    got = 0; at = -1; ro = 0; rd = 0; re = 0; rt = 0;
    for (int i = 0; i < bound && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1; at = cyc; ro = rsp_op; rd = rsp_data; re = rsp_err; rt = rsp_timeout;
      end
    end
    if (!got) chk("rsp_seen", 0, 1);
    tick();
  endtask

  initial begin
    int pc, nb, at;
    bit got;
    logic ro, re, rt;
    logic [7:0] rd;

    // reset state
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_cmd_count", int'(cmd_count), 0);
    chk("rst_outs", int'({newd, op, addr, din, rsp_valid, rsp_op, rsp_data, rsp_err, rsp_timeout}), 0);
    tick();

    // single write, done 20 cycles after the strobe
    nb = n_newd;
    push(1'b0, 7'h5A, 8'h3C, pc);
    wait_issue(nb + 1);
    chk("wr_latency", newd_cyc - pc, 2);
    chk("wr_issue", int'(iss_log[nb]), int'({1'b0, 7'h5A, 8'h3C}));
    repeat (20) tick();
    pulse_done(8'hEE, 1'b0);
    wait_rsp(20, got, at, ro, rd, re, rt);
    chk("wr_rsp", int'({ro, rd, re}), int'({1'b0, 8'h00, 1'b0}));
    chk("wr_one_newd", n_newd - nb, 1);

    // read returning 0x3C
    nb = n_newd;
    push(1'b1, 7'h5A, 8'h00, pc);
    wait_issue(nb + 1);
    repeat (5) tick();
    pulse_done(8'h3C, 1'b0);
    wait_rsp(20, got, at, ro, rd, re, rt);
    chk("rd_rsp", int'({ro, rd, re}), int'({1'b1, 8'h3C, 1'b0}));

    // fill to capacity with master stalled, fifth push held off
    busy = 1'b1;
    nb = n_newd;
    for (int i = 0; i < 4; i++) push(1'b0, 7'(8'h10 + i), 8'(i), pc);
    @(negedge clk);
    chk("full_count", int'(cmd_count), 4);
    chk("full_ready", int'(cmd_ready), 0);
    tick();
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_addr = 7'h14; cmd_data = 8'h04;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("fifth_held", int'(cmd_ready), 0);
      tick();
    end
    busy = 1'b0;
    push(1'b0, 7'h14, 8'h04, pc);
    for (int i = 0; i < 5; i++) begin
      wait_issue(nb + i + 1);
      repeat (3) tick();
      pulse_done(8'h00, 1'b0);
      wait_rsp(20, got, at, ro, rd, re, rt);
    end
    for (int i = 0; i < 5; i++)
      chk("fifo_order", int'(iss_log[nb + i]), int'({1'b0, 7'(8'h10 + i), 8'(i)}));

    // NACK response left unconsumed blocks the next issue
    rsp_ready = 1'b0;
    nb = n_newd;
    push(1'b0, 7'h22, 8'h11, pc);
    wait_issue(nb + 1);
    pulse_done(8'h00, 1'b1);
    wait_rsp(20, got, at, ro, rd, re, rt);
    chk("nack_rsp", int'({ro, rd, re}), int'({1'b0, 8'h00, 1'b1}));
    push(1'b0, 7'h23, 8'h12, pc);
    repeat (10) tick();
    @(negedge clk);
    chk("nack_stall_newd", n_newd - nb, 1);
    chk("nack_stall_valid", int'(rsp_valid), 1);
    tick();
    rsp_ready = 1'b1;
    wait_issue(nb + 2);
    pulse_done(8'h00, 1'b0);
    wait_rsp(20, got, at, ro, rd, re, rt);

    // done already high when the command starts is not a completion
    done = 1'b1; dout = 8'h77;
    nb = n_newd;
    push(1'b1, 7'h30, 8'h00, pc);
    wait_issue(nb + 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("stale_done", int'(rsp_valid), 0);
      tick();
    end
    done = 1'b0;
    tick();
    pulse_done(8'h77, 1'b0);
    wait_rsp(20, got, at, ro, rd, re, rt);
    chk("fresh_done_rsp", int'({ro, rd}), int'({1'b1, 8'h77}));

    // reset while waiting with two commands queued
    nb = n_newd;
    push(1'b0, 7'h40, 8'h01, pc);
    wait_issue(nb + 1);
    push(1'b0, 7'h41, 8'h02, pc);
    push(1'b0, 7'h42, 8'h03, pc);
    @(negedge clk);
    chk("pre_rst_count", int'(cmd_count), 2);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_outs", int'({cmd_count, newd, op, addr, din, rsp_valid, rsp_op, rsp_data, rsp_err, rsp_timeout}), 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", int'({cmd_count, newd, rsp_valid}), 0);
      tick();
    end
    pulse_done(8'h55, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("orphan_done", int'(rsp_valid), 0);
      tick();
    end

    // no done at all: watchdog or indefinite wait
    nb = n_newd;
    push(1'b0, 7'h50, 8'h99, pc);
    wait_issue(nb + 1);
`ifdef I2C_CMDQ_TIMEOUT_EN
    wait_rsp(100, got, at, ro, rd, re, rt);
    chk("to_latency", at - newd_cyc, TO);
    chk("to_rsp", int'({ro, rd, re, rt}), int'({1'b0, 8'h00, 1'b1, 1'b1}));
`else
    for (int i = 0; i < TO + 10; i++) begin
      @(negedge clk);
      chk("no_to_valid", int'(rsp_valid), 0);
      tick();
    end
    pulse_done(8'h00, 1'b0);
    wait_rsp(20, got, at, ro, rd, re, rt);
    chk("no_to_rsp", int'({rd, re, rt}), 0);
`endif

    repeat (5) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end
endmodule
